// File: rtl/mux16_arbiter.sv
// Round-robin arbiter that owns the select line of an external 16:1 data mux.
// A grant lasts until the owner's last beat, the beat limit, or until the owner drops its request.
module mux16_arbiter #(
  parameter int unsigned MAX_BEATS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic [15:0] last,
  input  logic        out_ready,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        out_valid,
  output logic        busy
);

  // state | meaning
  // IDLE  | channel free; arbitrate from ptr when armed
  // OWN   | requester sel owns the channel; beats flow on out_valid && out_ready
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam logic [7:0] LIMIT = 8'(MAX_BEATS);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  ptr;
  logic [3:0]  ptr_nxt;
  logic [3:0]  sel_nxt;
  logic [15:0] gnt_nxt;
  logic        busy_nxt;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic [7:0]  cnt_inc;
  logic [3:0]  win;
  logic        found;
  logic        armed;
  logic        beat;
  logic        rel;

  // First requester at or after ptr, wrapping modulo 16.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (!found && req[ptr + 4'(k)]) begin
        win   = ptr + 4'(k);
        found = 1'b1;
      end
    end
  end

  assign out_valid = (state == OWN) && req[sel];
  assign beat      = out_valid && out_ready;
  assign cnt_inc   = cnt + 8'd1;
  assign rel       = (state == OWN) &&
                     (!req[sel] || (beat && (last[sel] || (cnt_inc == LIMIT))));

  // Arbitration is held off for the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (armed && found) state_nxt = OWN;
      OWN:     if (rel)            state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_nxt  = sel;
    gnt_nxt  = gnt;
    busy_nxt = busy;
    ptr_nxt  = ptr;
    cnt_nxt  = cnt;
    case (state)
      IDLE: begin
        if (armed && found) begin
          sel_nxt  = win;
          gnt_nxt  = 16'd1 << win;
          busy_nxt = 1'b1;
          cnt_nxt  = '0;
        end
      end
      OWN: begin
        if (rel) begin
          ptr_nxt  = sel + 4'd1;
          gnt_nxt  = '0;
          busy_nxt = 1'b0;
          cnt_nxt  = '0;
        end else if (beat) begin
          cnt_nxt  = cnt_inc;
        end
      end
      default: begin
        gnt_nxt  = '0;
        busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel  <= '0;
      gnt  <= '0;
      busy <= 1'b0;
      ptr  <= '0;
      cnt  <= '0;
    end else begin
      sel  <= sel_nxt;
      gnt  <= gnt_nxt;
      busy <= busy_nxt;
      ptr  <= ptr_nxt;
      cnt  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mux16_arbiter.sv
// Bench for mux16_arbiter: four instances (beat limits 8, 4, 2, 1) share one stimulus stream
// and are checked every cycle against a behavioural ownership model plus directed scenarios.
module tb_mux16_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = '0;
  logic [15:0] last = '0;
  logic        out_ready = 1'b0;

  logic [3:0]  sel_o   [4];
  logic [15:0] gnt_o   [4];
  logic        valid_o [4];
  logic        busy_o  [4];

  always #5 clk = ~clk;

  mux16_arbiter u0 (.clk(clk), .rst_n(rst_n), .req(req), .last(last), .out_ready(out_ready),
                    .sel(sel_o[0]), .gnt(gnt_o[0]), .out_valid(valid_o[0]), .busy(busy_o[0]));
  mux16_arbiter #(.MAX_BEATS(4)) u1 (.clk(clk), .rst_n(rst_n), .req(req), .last(last), .out_ready(out_ready),
                    .sel(sel_o[1]), .gnt(gnt_o[1]), .out_valid(valid_o[1]), .busy(busy_o[1]));
  mux16_arbiter #(.MAX_BEATS(2)) u2 (.clk(clk), .rst_n(rst_n), .req(req), .last(last), .out_ready(out_ready),
                    .sel(sel_o[2]), .gnt(gnt_o[2]), .out_valid(valid_o[2]), .busy(busy_o[2]));
  mux16_arbiter #(.MAX_BEATS(1)) u3 (.clk(clk), .rst_n(rst_n), .req(req), .last(last), .out_ready(out_ready),
                    .sel(sel_o[3]), .gnt(gnt_o[3]), .out_valid(valid_o[3]), .busy(busy_o[3]));

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: who owns the channel, where the search starts, beats so far.
  int mb     [4] = '{8, 4, 2, 1};
  bit m_arm  [4];
  bit m_own  [4];
  int m_sel  [4];
  int m_ptr  [4];
  int m_cnt  [4];

  // Samples taken at the last negedge.
  logic [3:0]  s_sel   [4];
  logic [15:0] s_gnt   [4];
  logic        s_valid [4];
  logic        s_busy  [4];

  typedef struct {
    logic [15:0] r;
    logic [15:0] l;
    logic        rd;
    logic [3:0]  esel;
    logic [15:0] egnt;
    logic        ebusy;
    logic        evalid;
  } vec_t;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_arm[i] = 1'b0;
      m_own[i] = 1'b0;
      m_sel[i] = 0;
      m_ptr[i] = 0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic model_update(input logic [15:0] r, input logic [15:0] l, input logic rd);
    for (int i = 0; i < 4; i++) begin
      if (!m_arm[i]) begin
        m_arm[i] = 1'b1;
      end else if (!m_own[i]) begin
        if (r != 16'h0) begin
          bit got = 1'b0;
          for (int k = 0; k < 16; k++) begin
            int idx = (m_ptr[i] + k) % 16;
            if (!got && r[idx]) begin
              got      = 1'b1;
              m_sel[i] = idx;
              m_own[i] = 1'b1;
              m_cnt[i] = 0;
            end
          end
        end
      end else begin
        bit done = 1'b0;
        if (!r[m_sel[i]]) done = 1'b1;
        else if (rd) begin
          m_cnt[i] = m_cnt[i] + 1;
          if (l[m_sel[i]] || m_cnt[i] == mb[i]) done = 1'b1;
        end
        if (done) begin
          m_ptr[i] = (m_sel[i] + 1) % 16;
          m_own[i] = 1'b0;
        end
      end
    end
  endtask

  // Called #1 after a posedge; returns #1 after the next posedge.
  task automatic step(input logic [15:0] r, input logic [15:0] l, input logic rd);
    req = r;
    last = l;
    out_ready = rd;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] eg;
      eg = m_own[i] ? 16'(1 << m_sel[i]) : 16'h0;
      chk($sformatf("sel[%0d]", i),   16'(sel_o[i]), 16'(m_sel[i]));
      chk($sformatf("gnt[%0d]", i),   gnt_o[i], eg);
      chk($sformatf("busy[%0d]", i),  16'(busy_o[i]), 16'(m_own[i]));
      chk($sformatf("valid[%0d]", i), 16'(valid_o[i]), 16'(m_own[i] && r[m_sel[i]]));
      s_sel[i]   = sel_o[i];
      s_gnt[i]   = gnt_o[i];
      s_valid[i] = valid_o[i];
      s_busy[i]  = busy_o[i];
    end
    model_update(r, l, rd);
    @(posedge clk);
    #1;
  endtask

  // Asserts reset between edges, checks the immediate effect, releases after the next edge.
  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_gnt[%0d]", i),   gnt_o[i], 16'h0);
      chk($sformatf("rst_busy[%0d]", i),  16'(busy_o[i]), 16'h0);
      chk($sformatf("rst_valid[%0d]", i), 16'(valid_o[i]), 16'h0);
      chk($sformatf("rst_sel[%0d]", i),   16'(sel_o[i]), 16'h0);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [9];
    int   gs [$];
    bit   prev;
    int   beats;
    logic [15:0] rr;

    tbl[0] = '{16'h0020, 16'h0000, 1'b1, 4'd0, 16'h0000, 1'b0, 1'b0};
    tbl[1] = '{16'h0020, 16'h0000, 1'b1, 4'd0, 16'h0000, 1'b0, 1'b0};
    tbl[2] = '{16'h0020, 16'h0000, 1'b1, 4'd5, 16'h0020, 1'b1, 1'b1};
    tbl[3] = '{16'h0020, 16'h0000, 1'b1, 4'd5, 16'h0020, 1'b1, 1'b1};
    tbl[4] = '{16'h0020, 16'h0020, 1'b1, 4'd5, 16'h0020, 1'b1, 1'b1};
    tbl[5] = '{16'h0000, 16'h0000, 1'b1, 4'd5, 16'h0000, 1'b0, 1'b0};
    tbl[6] = '{16'h0041, 16'h0000, 1'b1, 4'd5, 16'h0000, 1'b0, 1'b0};
    tbl[7] = '{16'h0041, 16'h0040, 1'b1, 4'd6, 16'h0040, 1'b1, 1'b1};
    tbl[8] = '{16'h0000, 16'h0000, 1'b1, 4'd6, 16'h0000, 1'b0, 1'b0};

    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Single requester, three beats, then ptr moves to 6.
    for (int v = 0; v < 9; v++) begin
      step(tbl[v].r, tbl[v].l, tbl[v].rd);
      chk($sformatf("tbl%0d_sel", v),   16'(s_sel[0]), 16'(tbl[v].esel));
      chk($sformatf("tbl%0d_gnt", v),   s_gnt[0], tbl[v].egnt);
      chk($sformatf("tbl%0d_busy", v),  16'(s_busy[0]), 16'(tbl[v].ebusy));
      chk($sformatf("tbl%0d_valid", v), 16'(s_valid[0]), 16'(tbl[v].evalid));
    end

    // Round-robin between 0 and 15 with wrap.
    do_reset();
    prev = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step(16'h8001, 16'hFFFF, 1'b1);
      if (s_busy[0] && !prev) gs.push_back(int'(s_sel[0]));
      prev = s_busy[0];
    end
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr_grant%0d", k), (k < gs.size()) ? 16'(gs[k]) : 16'hFFFF, (k % 2 == 1) ? 16'd15 : 16'd0);

    // Forced release at 4 beats, one idle cycle, re-grant to 2.
    do_reset();
    beats = 0;
    for (int c = 0; c < 8; c++) begin
      step(16'h0004, 16'h0000, 1'b1);
      if (c >= 2 && c <= 6 && s_valid[1]) beats++;
      if (c == 6) chk("forced_idle_busy", 16'(s_busy[1]), 16'h0);
      if (c == 7) begin
        chk("forced_regrant_busy", 16'(s_busy[1]), 16'h1);
        chk("forced_regrant_sel", 16'(s_sel[1]), 16'd2);
      end
    end
    chk("forced_beats", 16'(beats), 16'd4);

    // Last beat coincides with limit 2: one release, then ptr=5.
    do_reset();
    beats = 0;
    step(16'h0010, 16'h0000, 1'b1);
    step(16'h0010, 16'h0000, 1'b1);
    step(16'h0010, 16'h0000, 1'b1);
    beats += int'(s_valid[2]);
    step(16'h0010, 16'h0010, 1'b1);
    beats += int'(s_valid[2]);
    step(16'h0030, 16'h0000, 1'b1);
    beats += int'(s_valid[2]);
    chk("coincide_idle_busy", 16'(s_busy[2]), 16'h0);
    step(16'h0030, 16'h0000, 1'b0);
    chk("coincide_beats", 16'(beats), 16'd2);
    chk("coincide_next_sel", 16'(s_sel[2]), 16'd5);
    chk("coincide_next_busy", 16'(s_busy[2]), 16'h1);

    // Backpressure on owner 7, then abandon; next search starts at 8.
    do_reset();
    step(16'h0080, 16'h0000, 1'b0);
    step(16'h0080, 16'h0000, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step(16'h0080, 16'h0000, 1'b0);
      chk("stall_gnt", s_gnt[0], 16'h0080);
      chk("stall_limit1_busy", 16'(s_busy[3]), 16'h1);
    end
    step(16'h0000, 16'h0000, 1'b0);
    step(16'h0181, 16'h0000, 1'b1);
    chk("abandon_idle_busy", 16'(s_busy[0]), 16'h0);
    step(16'h0181, 16'h0000, 1'b0);
    chk("abandon_next_sel", 16'(s_sel[0]), 16'd8);

    // Reset in the middle of a grant to 9, then arbitration restarts from 0.
    do_reset();
    step(16'h0200, 16'h0000, 1'b0);
    step(16'h0200, 16'h0000, 1'b0);
    step(16'h0200, 16'h0000, 1'b0);
    chk("pre_reset_sel", 16'(s_sel[0]), 16'd9);
    do_reset();
    step(16'h0201, 16'h0000, 1'b0);
    chk("post_reset_arm_busy", 16'(s_busy[0]), 16'h0);
    step(16'h0201, 16'h0000, 1'b0);
    step(16'h0201, 16'h0000, 1'b0);
    chk("post_reset_sel", 16'(s_sel[0]), 16'd0);
    chk("post_reset_gnt", s_gnt[0], 16'h0001);

    // Random traffic against the model.
    do_reset();
    rr = 16'($urandom);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) rr = rr ^ 16'(1 << $urandom_range(0, 15));
      if ($urandom_range(0, 40) == 0) rr = 16'h0;
      if ($urandom_range(0, 40) == 0) rr = 16'($urandom);
      step(rr, 16'($urandom) & 16'($urandom), $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 249) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux16_arbiter.md
MUX16_ARBITER -- requirements
Module: mux16_arbiter

Interface
REQ-001 The module SHALL have parameter MAX_BEATS, default 8, giving the maximum beats per grant; the legal range is 1..255.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port req, input, 16 bits: req[i] high means requester i wants the shared channel.
REQ-005 The module SHALL have port last, input, 16 bits: last[i] marks the current beat of requester i as its final beat.
REQ-006 The module SHALL have port out_ready, input, 1 bit: the downstream consumer accepts a beat.
REQ-007 The module SHALL have port sel, output, 4 bits: select code driven to the S input of the external 16:1 data mux.
REQ-008 The module SHALL have port gnt, output, 16 bits: one-hot grant, with gnt[sel] high while owned.
REQ-009 The module SHALL have port out_valid, output, 1 bit: the muxed beat is valid.
REQ-010 The module SHALL have port busy, output, 1 bit: the channel is currently owned.

Function
REQ-011 The module SHALL implement a two-state FSM with states IDLE and OWN; all outputs SHALL be registered except out_valid.
REQ-012 The module SHALL keep a 4-bit round-robin pointer ptr, where search priority is ptr, ptr+1, ..., ptr+15 (mod 16).
REQ-013 In IDLE with req != 0, the module SHALL select the first set index w in priority order, load sel=w, set gnt to one-hot(w), set busy=1, clear the beat counter and enter OWN on the next edge; this gives a 1-cycle grant latency.
REQ-014 In IDLE with req == 0, the module SHALL hold sel, keep gnt=0 and busy=0, and hold ptr.
REQ-015 In OWN, out_valid SHALL equal req[sel] combinationally; in IDLE, out_valid SHALL be 0.
REQ-016 A beat transfer SHALL be defined as out_valid && out_ready; on each beat transfer the 8-bit beat counter SHALL increment.
REQ-017 Release SHALL occur in OWN on any of the following:
- a beat transfer with last[sel]=1;
- a beat transfer that makes the counter equal MAX_BEATS (forced release);
- req[sel]=0 (abandon).
REQ-018 On release, the module SHALL set ptr=sel+1 (mod 16, so 15 wraps to 0), clear gnt and busy, and enter IDLE; sel SHALL hold its value.
REQ-019 No back-to-back grant SHALL occur: at least one IDLE cycle separates grants, and re-arbitration happens in that cycle.
REQ-020 If the last-beat and counter-limit conditions coincide, the module SHALL produce a single release, identical to REQ-018.
REQ-021 While in OWN, req changes on non-owner lines SHALL NOT affect sel, gnt or the counter.
REQ-022 With out_ready=0, the module SHALL hold state indefinitely; there is no timeout on stall, and the counter counts only transferred beats.
REQ-023 With MAX_BEATS=1, every grant SHALL last exactly one transfer.
REQ-024 gnt SHALL never have more than one bit set, and in OWN gnt SHALL equal one-hot(sel).

Reset
REQ-025 When rst_n=0, the module SHALL immediately, without waiting for clk, force state=IDLE, sel=0, gnt=0, busy=0, ptr=0 and counter=0, which makes out_valid=0.
REQ-026 Reset asserted mid-grant SHALL abort the grant with no further beats, and after release of reset the first arbitration SHALL start from ptr=0.
REQ-027 Reset deassertion SHALL take effect at the next rising clk edge; the first grant can occur no earlier than one edge later.

Verification
REQ-028 Single requester: req=16'h0020, last asserted on the 3rd beat, out_ready=1 -> sel=5, gnt=16'h0020 one cycle after req, 3 beats transferred, then gnt=0 and ptr=6.
REQ-029 Round-robin fairness: req=16'h8001 held, last=16'hFFFF -> grants alternate 0, 15, 0, 15, with one IDLE cycle between grants, demonstrating wrap-around 15->0.
REQ-030 Forced release: MAX_BEATS=4, req=16'h0004, last=0 -> exactly 4 beats on sel=2, then release, and re-grant to 2 after one IDLE cycle if no other requester is active.
REQ-031 Backpressure and abandon: in OWN with sel=7, out_ready=0 for 10 cycles -> the counter stays 0 and gnt stays 16'h0080; then req[7] drops -> release and ptr=8.
REQ-032 Async reset mid-grant: in OWN with sel=9, pulse rst_n low between clock edges -> gnt, busy and out_valid go 0 immediately, and after reset with req=16'h0201 the grant goes to 0.
REQ-033 Simultaneous last and limit: MAX_BEATS=2 with last on beat 2 -> a single release, ptr=sel+1, and no extra beat.
